// File: rtl/uart_alu_top.sv
// rtl/uart_alu_top.sv - UART ALU top: 8N1 UART, packet parser, 32-bit add/mul unit
//
// The host sends packets on rx_i. Depending on the opcode, the block echoes the
// payload or returns a 32-bit add/mul result on tx_o. Unknown opcodes are parsed
// and their payload is discarded.
// Optional feature macro: UART_ALU_MUL_EN enables opcode 0x11 and its iterative
// shift-add multiplier. Without it, 0x11 is handled as an unknown opcode.
//
// Parameters:
//   PRESCALE_P - UART prescale; bit period is PRESCALE_P*8 clocks
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous active-high reset
//   rx_i - serial in from host, 8N1, LSB first, idle high (double-flop synchronised)
//   tx_o - serial out to host, 8N1, LSB first, idle high
module uart_alu_top #(
  parameter int PRESCALE_P = 31
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  output logic tx_o
);
  localparam int BIT_CLKS  = PRESCALE_P * 8;
  localparam int HALF_CLKS = PRESCALE_P * 4;
  localparam logic [15:0] BIT_M1  = 16'(BIT_CLKS - 1);
  localparam logic [15:0] HALF_M1 = 16'(HALF_CLKS - 1);

  typedef enum logic [2:0] {S_IDLE, S_RSVD, S_LEN_LO, S_LEN_HI, S_PAYLOAD, S_RESULT} state_t;

  // ---------------- receiver ----------------
  logic        rx_m, rx_s, rx_d;
  logic        rx_busy;
  logic [15:0] rx_cnt;
  logic [3:0]  rx_bit;
  logic [7:0]  rx_sh, rx_data;
  logic        rx_pend;
  logic        consume;

  // Start is a falling edge, so a framing-error byte whose stop bit is still low
  // cannot retrigger the receiver until the line has returned high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1; rx_s <= 1'b1; rx_d <= 1'b1;
      rx_busy <= 1'b0; rx_cnt <= '0; rx_bit <= '0;
      rx_sh <= '0; rx_data <= '0; rx_pend <= 1'b0;
    end else begin
      rx_m <= rx_i;
      rx_s <= rx_m;
      rx_d <= rx_s;
      if (consume) rx_pend <= 1'b0;
      if (!rx_busy) begin
        if (rx_d && !rx_s) begin
          rx_busy <= 1'b1;
          rx_cnt  <= HALF_M1;
          rx_bit  <= '0;
        end
      end else if (rx_cnt != 16'd0) begin
        rx_cnt <= rx_cnt - 16'd1;
      end else begin
        rx_cnt <= BIT_M1;
        rx_bit <= rx_bit + 4'd1;
        if (rx_bit == 4'd0) begin
          if (rx_s) rx_busy <= 1'b0;          // glitch, not a real start bit
        end else if (rx_bit != 4'd9) begin
          rx_sh <= {rx_s, rx_sh[7:1]};
        end else begin
          rx_busy <= 1'b0;
          if (rx_s) begin                     // good stop bit: byte valid, overwrites any unconsumed byte
            rx_data <= rx_sh;
            rx_pend <= 1'b1;
          end
        end
      end
    end
  end

  // ---------------- 4-entry TX FIFO ----------------
  logic [7:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fifo_cnt;
  logic       push, do_push, pop;
  logic [7:0] push_data;

  assign do_push = push && (fifo_cnt != 3'd4);   // push while full is dropped

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0; rd_ptr <= '0; fifo_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + {2'b00, do_push} - {2'b00, pop};
    end
  end

  // ---------------- transmitter ----------------
  logic        tx_busy, tx_free;
  logic [15:0] tx_cnt;
  logic [3:0]  tx_bit;
  logic [8:0]  tx_sh;

  // Free at the last clock of the stop bit so the next byte follows with no gap.
  assign tx_free = !tx_busy || (tx_cnt == 16'd0 && tx_bit == 4'd9);
  assign pop     = tx_free && (fifo_cnt != 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_o <= 1'b1; tx_busy <= 1'b0; tx_cnt <= '0; tx_bit <= '0; tx_sh <= '1;
    end else if (pop) begin
      tx_sh   <= {1'b1, fifo_mem[rd_ptr]};
      tx_o    <= 1'b0;
      tx_cnt  <= BIT_M1;
      tx_bit  <= '0;
      tx_busy <= 1'b1;
    end else if (tx_free) begin
      tx_busy <= 1'b0;
      tx_o    <= 1'b1;
    end else if (tx_cnt != 16'd0) begin
      tx_cnt <= tx_cnt - 16'd1;
    end else begin
      tx_cnt <= BIT_M1;
      tx_bit <= tx_bit + 4'd1;
      tx_o   <= tx_sh[0];
      tx_sh  <= {1'b1, tx_sh[8:1]};
    end
  end

  // ---------------- packet parser ----------------
  state_t      state, state_nx;
  logic [7:0]  opcode, len_lo;
  logic [15:0] len_full, pay_cnt;
  logic [1:0]  byte_idx, res_idx;
  logic [23:0] opnd;
  logic [31:0] operand, acc;
  logic        is_add, is_mul, is_echo, op_done, mul_busy;

  assign len_full = {rx_data, len_lo};
  assign operand  = {rx_data, opnd};            // completed little-endian operand
  assign is_add   = (opcode == 8'h10);
  assign is_echo  = (opcode == 8'hEC);
`ifdef UART_ALU_MUL_EN
  assign is_mul   = (opcode == 8'h11);
`else
  assign is_mul   = 1'b0;
  assign mul_busy = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    consume   = 1'b0;
    push      = 1'b0;
    push_data = rx_data;
    op_done   = 1'b0;
    case (state)
      S_IDLE:   if (rx_pend) begin consume = 1'b1; state_nx = S_RSVD;   end
      S_RSVD:   if (rx_pend) begin consume = 1'b1; state_nx = S_LEN_LO; end
      S_LEN_LO: if (rx_pend) begin consume = 1'b1; state_nx = S_LEN_HI; end
      S_LEN_HI: if (rx_pend) begin
        consume = 1'b1;
        if (len_full > 16'd4)     state_nx = S_PAYLOAD;
        else if (is_add || is_mul) state_nx = S_RESULT;
        else                       state_nx = S_IDLE;
      end
      S_PAYLOAD: if (rx_pend && !mul_busy) begin
        consume = 1'b1;
        push    = is_echo;
        op_done = (byte_idx == 2'd3);
        if (pay_cnt == 16'd1) state_nx = (is_add || is_mul) ? S_RESULT : S_IDLE;
      end
      S_RESULT: if (!mul_busy) begin
        push      = 1'b1;
        push_data = 8'(acc >> {res_idx, 3'b000});
        if (res_idx == 2'd3) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

`ifdef UART_ALU_MUL_EN
  logic [31:0] mcand, mplier, prod;
  logic [5:0]  mul_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode <= '0; len_lo <= '0; pay_cnt <= '0; byte_idx <= '0;
      res_idx <= '0; opnd <= '0; acc <= '0;
`ifdef UART_ALU_MUL_EN
      mcand <= '0; mplier <= '0; prod <= '0; mul_cnt <= '0; mul_busy <= 1'b0;
`endif
    end else begin
      if (consume) begin
        case (state)
          S_IDLE: begin
            opcode <= rx_data;
`ifdef UART_ALU_MUL_EN
            acc <= (rx_data == 8'h11) ? 32'd1 : 32'd0;
`else
            acc <= 32'd0;
`endif
          end
          S_LEN_LO: len_lo <= rx_data;
          S_LEN_HI: begin
            pay_cnt  <= len_full - 16'd4;     // only used when LEN > 4
            byte_idx <= '0;
          end
          S_PAYLOAD: begin
            pay_cnt  <= pay_cnt - 16'd1;
            byte_idx <= byte_idx + 2'd1;
            opnd     <= {rx_data, opnd[23:8]};
          end
          default: ;
        endcase
      end
      if (op_done && is_add) acc <= acc + operand;
      if (state == S_RESULT && push) res_idx <= res_idx + 2'd1;
`ifdef UART_ALU_MUL_EN
      // Shift-add over 32 multiplier bits; result lands in acc on the final clock.
      if (op_done && is_mul) begin
        mcand    <= acc;
        mplier   <= operand;
        prod     <= '0;
        mul_cnt  <= 6'd32;
        mul_busy <= 1'b1;
      end else if (mul_busy) begin
        if (mul_cnt == 6'd0) begin
          acc      <= prod;
          mul_busy <= 1'b0;
        end else begin
          if (mplier[0]) prod <= prod + mcand;
          mcand   <= {mcand[30:0], 1'b0};
          mplier  <= {1'b0, mplier[31:1]};
          mul_cnt <= mul_cnt - 6'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_alu_top.sv
// tb/tb_uart_alu_top.sv - self-checking bench for uart_alu_top
module tb_uart_alu_top;
  localparam int PRE   = 2;
  localparam int BIT   = PRE * 8;
  localparam int HALF  = PRE * 4;
  localparam int FRAME = BIT * 10;
  localparam int LAT_LO = 9 * BIT + HALF;     // start edge to middle of stop bit
`ifdef UART_ALU_MUL_EN
  localparam bit MUL = 1'b1;
`else
  localparam bit MUL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx;

  always #5 clk = ~clk;

  uart_alu_top #(.PRESCALE_P(PRE)) dut (.clk(clk), .rst(rst), .rx_i(rx), .tx_o(tx));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_run = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    n_run++;
    if (val < lo || val > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, val, lo, hi);
    end
  endtask

  // ---------------- serial monitor on tx ----------------
  logic [7:0] cap_q[$];
  int         cap_t[$];
  int         frame_err = 0;
  bit         mon_en = 1'b0;

  initial begin : monitor
    logic       prev;
    logic [7:0] b;
    int         t;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev && !tx) begin
        t = cyc;
        repeat (HALF) @(negedge clk);
        if (tx !== 1'b0) frame_err++;
        for (int i = 0; i < 8; i++) begin
          repeat (BIT) @(negedge clk);
          b[i] = tx;
        end
        repeat (BIT) @(negedge clk);
        if (tx !== 1'b1) frame_err++;
        cap_q.push_back(b);
        cap_t.push_back(t);
      end
      prev = tx;
    end
  end

  // ---------------- serial driver ----------------
  int last_t0;

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    last_t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask

  // ---------------- packet runner and reference model ----------------
  logic [7:0] pkt_q[$];
  logic [7:0] exp_q[$];

  task automatic run_pkt(input string name, input int bad_idx);
    cap_q.delete();
    cap_t.delete();
    @(negedge clk);
    for (int i = 0; i < pkt_q.size(); i++) begin
      send_byte(pkt_q[i], (i != bad_idx));
      if (i == bad_idx) begin
        drive_bit(1'b1);
        drive_bit(1'b1);
      end
    end
    repeat (6 * FRAME) @(negedge clk);
    check({name, "_count"}, cap_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++)
      check($sformatf("%s_byte%0d", name, i), cap_q[i], exp_q[i]);
  endtask

  // Expected reply computed straight from the packet rules.
  function automatic void model();
    int          len, npay;
    logic [7:0]  op;
    logic [31:0] a, w;
    exp_q.delete();
    op   = pkt_q[0];
    len  = int'({pkt_q[3], pkt_q[2]});
    if (len < 4) len = 4;
    npay = len - 4;
    if (op == 8'hEC) begin
      for (int i = 0; i < npay; i++) exp_q.push_back(pkt_q[4 + i]);
    end else if (op == 8'h10 || (op == 8'h11 && MUL)) begin
      a = (op == 8'h10) ? 32'd0 : 32'd1;
      for (int k = 0; k < npay / 4; k++) begin
        w = {pkt_q[7 + 4*k], pkt_q[6 + 4*k], pkt_q[5 + 4*k], pkt_q[4 + 4*k]};
        a = (op == 8'h10) ? a + w : a * w;
      end
      for (int i = 0; i < 4; i++) exp_q.push_back(a[8*i +: 8]);
    end
  endfunction

  task automatic load_bytes(input logic [127:0] bytes, input int n);
    pkt_q.delete();
    for (int k = 0; k < n; k++) pkt_q.push_back(bytes[8*(n-1-k) +: 8]);
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [4:0]   n;
    logic [127:0] pkt;
    logic [2:0]   ne;
    logic [31:0]  exp;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  initial begin : watchdog
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted");
    $fatal(1);
  end

  initial begin : main
    int lows;
    int d;

    vecs[0]  = '{5'd7,  128'hEC_00_07_00_41_42_43, 3'd3, 32'h00414243};
    vecs[1]  = '{5'd12, 128'h10_00_0C_00_01_00_00_00_FF_FF_FF_FF, 3'd4, 32'h00000000};
    vecs[2]  = '{5'd4,  128'h10_00_04_00, 3'd4, 32'h00000000};
    vecs[3]  = '{5'd12, 128'h11_00_0C_00_03_00_00_00_05_00_00_00,
                 MUL ? 3'd4 : 3'd0, MUL ? 32'h0F000000 : 32'h0};
    vecs[4]  = '{5'd5,  128'hEC_00_05_00_5A, 3'd1, 32'h0000005A};
    vecs[5]  = '{5'd6,  128'h55_00_06_00_AA_BB, 3'd0, 32'h0};
    vecs[6]  = '{5'd5,  128'hEC_00_05_00_5A, 3'd1, 32'h0000005A};
    vecs[7]  = '{5'd10, 128'h10_00_0A_00_05_00_00_00_07_00, 3'd4, 32'h05000000};
    vecs[8]  = '{5'd4,  128'h10_00_01_00, 3'd4, 32'h00000000};
    vecs[9]  = '{5'd12, 128'h10_00_0C_00_78_56_34_12_11_11_11_11, 3'd4, 32'h89674523};
    vecs[10] = '{5'd4,  128'hEC_00_02_00, 3'd0, 32'h0};
    vecs[11] = '{5'd6,  128'hEC_00_06_00_C3_3C, 3'd2, 32'h0000C33C};

    // Reset, then a long idle with no input.
    repeat (5) @(negedge clk);
    check("reset_tx", tx, 1'b1);
    rst = 1'b0;
    mon_en = 1'b1;
    lows = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("idle_low_cycles", lows, 0);
    check("idle_bytes", cap_q.size(), 0);

    // Table vectors.
    for (int v = 0; v < NV; v++) begin
      load_bytes(vecs[v].pkt, int'(vecs[v].n));
      exp_q.delete();
      for (int k = 0; k < vecs[v].ne; k++)
        exp_q.push_back(vecs[v].exp[8*(vecs[v].ne-1-k) +: 8]);
      run_pkt($sformatf("vec%0d", v), -1);
    end

    // Echo latency from the last byte's start bit.
    load_bytes(128'hEC_00_05_00_96, 5);
    model();
    run_pkt("echo_lat", -1);
    if (cap_t.size() > 0) check_range("echo_latency", cap_t[0] - last_t0, LAT_LO, LAT_LO + 7);
    else                  check("echo_latency_present", 0, 1);

    // Result latency with LEN=4 and back-to-back result bytes.
    load_bytes(128'h10_00_04_00, 4);
    model();
    run_pkt("res_lat", -1);
    if (cap_t.size() == 4) begin
      check_range("result_latency", cap_t[0] - last_t0, LAT_LO, LAT_LO + 44);
      for (int k = 0; k < 3; k++) check($sformatf("b2b_gap%0d", k), cap_t[k+1] - cap_t[k], FRAME);
    end else begin
      check("result_bytes_present", cap_t.size(), 4);
    end

    // A byte with a low stop bit is discarded and does not advance the parser.
    load_bytes(128'hEC_00_99_06_00_41_42, 7);
    exp_q.delete();
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h42);
    run_pkt("frame_err", 2);

    // Reset mid-payload, then an echo packet.
    load_bytes(128'h55_00_10_00_AA_BB, 6);
    @(negedge clk);
    foreach (pkt_q[i]) send_byte(pkt_q[i], 1'b1);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    load_bytes(128'hEC_00_05_00_5A, 5);
    model();
    run_pkt("rst_payload", -1);

    // Reset while a byte is on tx: line goes idle and nothing further is sent.
    load_bytes(128'hEC_00_06_00_41_42, 6);
    @(negedge clk);
    foreach (pkt_q[i]) send_byte(pkt_q[i], 1'b1);
    repeat (2 * BIT) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_tx_idle", tx, 1'b1);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2 * FRAME) @(negedge clk);
    cap_q.delete();
    repeat (3 * FRAME) @(negedge clk);
    check("rst_tx_no_bytes", cap_q.size(), 0);
    load_bytes(128'hEC_00_05_00_A5, 5);
    model();
    run_pkt("rst_tx_echo", -1);

    // Randomized packets against the reference model.
    for (int r = 0; r < 8; r++) begin
      int         np, lenf, sel;
      logic [7:0] op;
      sel = $urandom_range(0, 4);
      op  = (sel == 0) ? 8'hEC : (sel == 1) ? 8'h10 : (sel == 2) ? 8'h11 :
            (sel == 3) ? 8'h55 : 8'($urandom);
      np   = $urandom_range(0, 11);
      lenf = np + 4;
      if (np == 0 && $urandom_range(0, 1) == 1) lenf = $urandom_range(0, 3);
      pkt_q.delete();
      pkt_q.push_back(op);
      pkt_q.push_back(8'($urandom));
      pkt_q.push_back(8'(lenf));
      pkt_q.push_back(8'(lenf >> 8));
      for (int i = 0; i < np; i++) pkt_q.push_back(8'($urandom));
      model();
      run_pkt($sformatf("rand%0d_op%02h", r, op), -1);
    end

    check("tx_frame_errors", frame_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_alu_top.md
# uart_alu_top

Top-level FPGA block of the UART ALU: a full-duplex 8N1 UART plus a packet parser and 32-bit arithmetic unit. A host sends packets on `rx_i`; the block echoes payload or returns a 32-bit result on `tx_o`. It is the chip-level wrapper: the clock is the board oscillator (~27.75 MHz, 36.036 ns), and the serial pins go to the host UART.

## Interface
- `PRESCALE_P`, default 31: UART prescale; bit period = `PRESCALE_P`*8 clocks (248 clocks, ~111.9 kbaud at 27.75 MHz).
- `clk` input 1: sole clock; all logic on rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `rx_i` input 1: serial in from host, 8N1, LSB first, idle high. Double-flop synchronised internally.
- `tx_o` output 1: serial out to host, 8N1, LSB first, idle high.

## Operation
Packet format:
- Byte 0: opcode.
- Byte 1: reserved, ignored.
- Bytes 2-3: length LEN, little-endian. LEN counts all bytes, including the 4-byte header.
- Then LEN-4 payload bytes. LEN < 4 is treated as 4, meaning no payload.

Opcodes:
- 0xEC echo: each payload byte is retransmitted unchanged, in order.
- 0x10 add32: payload is little-endian 32-bit operands. The accumulator starts at 0; each operand is added mod 2^32. After the last payload byte, 4 result bytes are sent LSB first.
- 0x11 mul32: as add32, but the accumulator starts at 1 and each operand multiplies it; the low 32 bits are kept. Present only with `UART_ALU_MUL_EN`.
- Any other opcode: the header is parsed, the payload is consumed and discarded, and nothing is transmitted.
- If (LEN-4) is not a multiple of 4, the trailing 1-3 bytes are consumed and ignored.

Parser FSM:
- IDLE -> RSVD -> LEN_LO -> LEN_HI, one received byte per transition.
- From LEN_HI: go to PAYLOAD if LEN > 4; otherwise go to RESULT for add/mul, or back to IDLE for echo/unknown.
- PAYLOAD: counts bytes down to 0, then goes to RESULT (add/mul) or IDLE.
- RESULT: queues 4 bytes into the TX FIFO, then returns to IDLE.
- For mul, RESULT waits for multiplier done.

Receiver behaviour:
- Bytes with a framing error (stop bit low) are discarded and do not advance the FSM.
- A new RX byte arriving before the previous one is consumed overwrites it.

TX path:
- 4-entry TX FIFO feeds the UART transmitter.
- A push when the FIFO is full is dropped.
- The FIFO never blocks the parser.

## Timing
- Reset values: `tx_o`=1, FSM=IDLE, FIFO empty, accumulator 0, TX/RX shifters idle.
- Reset mid-frame or mid-packet aborts everything.
- First start-bit edge after reset release is recognised normally.
- RX byte valid: asserts at the middle of the stop bit.
- Echo latency: start bit on `tx_o` begins ≤3 clocks after RX byte valid, when the TX is idle.
- Back-to-back TX: consecutive bytes are sent back-to-back with no idle gap; a full frame is 2480 clocks.
- add32: the accumulator updates 1 clock after the 4th byte of an operand.
- mul32: iterative shift-add, ≤34 clocks per operand, which must finish well inside one byte time (2480 clocks).
- Result latency: first result start bit ≤40 clocks after the final payload byte valid (LEN=4: after the LEN_HI byte).
- Simultaneous RX byte valid and TX FIFO pop: both are serviced in the same cycle.

## Configuration
- `UART_ALU_MUL_EN` defined: opcode 0x11 is implemented, including the iterative multiplier.
- Not defined: the multiplier is not synthesised, and 0x11 is handled as an unknown opcode (payload consumed, no output).

## Test plan
- Reset 5 clocks then release, with no input -> `tx_o` stays 1 for 10000 clocks.
- Echo EC 00 07 00 41 42 43 -> `tx_o` emits 0x41, 0x42, 0x43 in order, with no extra bytes.
- Add 10 00 0C 00 01 00 00 00 FF FF FF FF -> emits 00 00 00 00 (wraps mod 2^32).
- Add 10 00 04 00 (no payload) -> emits 00 00 00 00.
- Mul (with macro) 11 00 0C 00 03 00 00 00 05 00 00 00 -> emits 0F 00 00 00. Without the macro -> no output, and a following echo packet still works.
- Unknown opcode 55 00 06 00 AA BB, then echo EC 00 05 00 5A -> only 0x5A is emitted. Repeat with `rst` asserted mid-payload: after reset the next echo packet works.
